// File: rtl/sw_pio_pkg.sv
// Shared definitions for the switch PIO: Avalon register offsets and edge-capture modes.
package sw_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Unknown modes fall back to capturing both directions.
  function automatic logic edge_select(input int mode, input logic rise, input logic fall);
    case (mode)
      EDGE_RISE: edge_select = rise;
      EDGE_FALL: edge_select = fall;
      default:   edge_select = rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch channel: 2-flop synchronizer, stability counter and debounced value.
module sw_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  output logic sync,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // stage p0/p1: metastability filter on the raw pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sw_raw;
      sync_p1 <= sync_p0;
    end
  end

  // The DEBOUNCE_CYCLES-th consecutive mismatch commits the new level.
  assign accept = (sync_p1 != stable) && (cnt == CNT_MAX);

  // stage stable: count mismatching clocks, any agreement restarts from zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_p1 == stable) begin
      cnt <= '0;
    end else if (accept) begin
      cnt    <= '0;
      stable <= sync_p1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign sync = sync_p1;
  assign rise = accept & sync_p1;
  assign fall = accept & ~sync_p1;

endmodule

// File: rtl/sw_debounce_ctrl.sv
// Debounced switch PIO with Avalon-MM registers, edge capture and a masked level interrupt.
module sw_debounce_ctrl
  import sw_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] sw_in
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edge_cap_nxt;
  logic [WIDTH-1:0] irq_mask;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .sw_raw (sw_in[i]),
      .sync   (sync[i]),
      .stable (stable[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
    assign edge_hit[i] = edge_select(EDGE_MODE, rise[i], fall[i]);
  end

  // Bits above WIDTH carry no meaning for any register.
  assign unused_wdata = ^writedata;

  // A fresh edge is OR-ed in after the clear so it survives a same-clock write-1-to-clear.
  always_comb begin
    edge_clr = '0;
    if (write && (address == ADDR_EDGE)) edge_clr = writedata[WIDTH-1:0];
    edge_cap_nxt = (edge_cap & ~edge_clr) | edge_hit;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = stable;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_cap;
      ADDR_RAW:  rd_mux[WIDTH-1:0] = sync;
    endcase
  end

  // register stage: reads sample the pre-write register values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
      irq_mask <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= edge_cap_nxt;
      if (write && (address == ADDR_MASK)) irq_mask <= writedata[WIDTH-1:0];
      if (read) readdata <= rd_mux;
      irq <= |(edge_cap & irq_mask);
    end
  end

endmodule

// File: tb/tb_sw_debounce_ctrl.sv
// Self-checking bench for sw_debounce_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_sw_debounce_ctrl;

  localparam int W  = 4;
  localparam int DB = 4;
  localparam int EM = 2;

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;
  logic [W-1:0]  sw_in;

  int errors;
  int checks;

  // Reference model: a switch level is accepted once the last DB synchronized
  // samples all disagree with the currently accepted level.
  logic [W-1:0]  m_p0, m_p1, m_stable, m_edge, m_mask;
  logic [DB-1:0] m_win [W];
  logic          m_irq;
  logic [31:0]   m_rd;

  sw_debounce_ctrl #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(EM)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .address  (address),
    .read     (read),
    .write    (write),
    .writedata(writedata),
    .readdata (readdata),
    .irq      (irq),
    .sw_in    (sw_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_p0 = '0; m_p1 = '0; m_stable = '0; m_edge = '0; m_mask = '0;
    m_irq = 1'b0; m_rd = '0;
    for (int i = 0; i < W; i++) m_win[i] = '0;
  endtask

  task automatic model_step();
    logic [W-1:0] ns;
    logic [W-1:0] clr;
    m_irq = |(m_edge & m_mask);
    if (read) begin
      case (address)
        2'd0: m_rd = 32'(m_stable);
        2'd1: m_rd = 32'(m_mask);
        2'd2: m_rd = 32'(m_edge);
        default: m_rd = 32'(m_p1);
      endcase
    end
    ns = m_stable;
    for (int i = 0; i < W; i++) begin
      m_win[i] = {m_win[i][DB-2:0], m_p1[i]};
      if (m_win[i] == {DB{~m_stable[i]}}) ns[i] = ~m_stable[i];
    end
    clr = (write && address == 2'd2) ? writedata[W-1:0] : '0;
    m_edge = (m_edge & ~clr) | (ns ^ m_stable);
    if (write && address == 2'd1) m_mask = writedata[W-1:0];
    m_stable = ns;
    m_p1 = m_p0;
    m_p0 = sw_in;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    v = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; write = 1'b1; writedata = d;
    tick();
    write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata actual=%h required=%h", readdata, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq actual=%b required=0", irq); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL reset_reg%0d actual=%h required=%h", a, v, 32'h0); end
    end
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    sw_in[1] = 1'b1;
    ticks(3);
    sw_in[1] = 1'b0;
    ticks(8);
    rd(2'd0, v);
    checks++;
    if (v !== 32'h0 || v !== m_rd) begin errors++; $display("FAIL glitch_data actual=%h required=%h", v, 32'h0); end
    rd(2'd2, v);
    checks++;
    if (v !== 32'h0 || v !== m_rd) begin errors++; $display("FAIL glitch_edge actual=%h required=%h", v, 32'h0); end
  endtask

  task automatic test_steady();
    logic [31:0] v;
    sw_in[0] = 1'b1;
    ticks(4);
    rd(2'd0, v);
    checks++;
    if (v !== 32'h0 || v !== m_rd) begin errors++; $display("FAIL steady_early actual=%h required=%h", v, 32'h0); end
    tick();
    rd(2'd0, v);
    checks++;
    if (v !== 32'h1 || v !== m_rd) begin errors++; $display("FAIL steady_data actual=%h required=%h", v, 32'h1); end
    rd(2'd2, v);
    checks++;
    if (v !== 32'h1 || v !== m_rd) begin errors++; $display("FAIL steady_edge actual=%h required=%h", v, 32'h1); end
    rd(2'd3, v);
    checks++;
    if (v !== 32'h1 || v !== m_rd) begin errors++; $display("FAIL steady_raw actual=%h required=%h", v, 32'h1); end
  endtask

  task automatic test_irq();
    wr(2'd1, 32'hFFFF_FFF4);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_mask actual=%b required=0", irq); end
    sw_in[2] = 1'b1;
    ticks(6);
    checks++;
    if (irq !== 1'b0 || irq !== m_irq) begin errors++; $display("FAIL irq_before_edge actual=%b required=0", irq); end
    tick();
    checks++;
    if (irq !== 1'b1 || irq !== m_irq) begin errors++; $display("FAIL irq_assert actual=%b required=1", irq); end
    wr(2'd2, 32'h4);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_clear_same_clk actual=%b required=1", irq); end
    tick();
    checks++;
    if (irq !== 1'b0 || irq !== m_irq) begin errors++; $display("FAIL irq_cleared actual=%b required=0", irq); end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    sw_in[0] = 1'b0;
    ticks(5);
    wr(2'd2, 32'h1);
    rd(2'd2, v);
    checks++;
    if (v !== 32'h1 || v !== m_rd) begin errors++; $display("FAIL collision_edge actual=%h required=%h", v, 32'h1); end
    wr(2'd2, 32'h1);
    rd(2'd2, v);
    checks++;
    if (v !== 32'h0 || v !== m_rd) begin errors++; $display("FAIL w1c_edge actual=%h required=%h", v, 32'h0); end
    rd(2'd0, v);
    checks++;
    if (v !== 32'h4 || v !== m_rd) begin errors++; $display("FAIL collision_data actual=%h required=%h", v, 32'h4); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    sw_in[3] = 1'b1;
    ticks(4);
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL midreset_async actual=%h/%b required=0/0", readdata, irq); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      checks++;
      if (v !== 32'h0 || v !== m_rd) begin errors++; $display("FAIL midreset_reg%0d actual=%h required=%h", a, v, 32'h0); end
    end
    tick();
    rd(2'd0, v);
    checks++;
    if (v !== 32'h0 || v !== m_rd) begin errors++; $display("FAIL midreset_early actual=%h required=%h", v, 32'h0); end
    tick();
    rd(2'd0, v);
    checks++;
    if (v !== 32'hC || v !== m_rd) begin errors++; $display("FAIL midreset_data actual=%h required=%h", v, 32'hC); end
    rd(2'd2, v);
    checks++;
    if (v !== 32'hC || v !== m_rd) begin errors++; $display("FAIL midreset_edge actual=%h required=%h", v, 32'hC); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(5) == 0) sw_in[i] = ~sw_in[i];
      address   = 2'($urandom_range(3));
      read      = ($urandom_range(2) == 0);
      write     = ($urandom_range(3) == 0);
      writedata = $urandom;
      tick();
      read  = 1'b0;
      write = 1'b0;
      checks++;
      if (readdata !== m_rd) begin errors++; $display("FAIL random_readdata cycle=%0d actual=%h required=%h", n, readdata, m_rd); end
      checks++;
      if (irq !== m_irq) begin errors++; $display("FAIL random_irq cycle=%0d actual=%b required=%b", n, irq, m_irq); end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset_n = 1'b0; address = '0; read = 1'b0; write = 1'b0; writedata = '0; sw_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_glitch();
    test_steady();
    test_irq();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/sw_debounce_ctrl.md
SW_DEBOUNCE_CTRL -- requirements
Module: sw_debounce_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of switch inputs, range 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable clocks needed to accept a change (1 ms at 50 MHz), minimum 2.
REQ-003 SHALL have parameter EDGE_MODE, default 2: edge-capture type, where 0 = rising, 1 = falling, 2 = any.
REQ-004 SHALL have port clk, input, 1 bit: system clock.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port address, input, 2 bits: Avalon-MM register select.
REQ-007 SHALL have port read, input, 1 bit: Avalon read strobe.
REQ-008 SHALL have port write, input, 1 bit: Avalon write strobe.
REQ-009 SHALL have port writedata, input, 32 bits: Avalon write data.
REQ-010 SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 SHALL have port irq, output, 1 bit: level interrupt request.
REQ-012 SHALL have port sw_in, input, WIDTH bits: raw asynchronous switch inputs.

Function
REQ-013 SHALL pass each sw_in bit through a 2-flop synchronizer to produce sync[i].
REQ-014 SHALL keep a debounced value stable[i] and a counter cnt[i] for each bit.
REQ-015 SHALL clear cnt[i] on every clock where sync[i] == stable[i].
REQ-016 SHALL, while sync[i] != stable[i], increment cnt[i] and load stable[i] <= sync[i] with cnt[i] cleared on the clock where cnt[i] == DEBOUNCE_CYCLES-1; the new value is therefore accepted after exactly DEBOUNCE_CYCLES consecutive mismatching clocks.
REQ-017 SHALL make a glitch that reverts before acceptance restart the count from 0, leaving stable unchanged.
REQ-018 SHALL size cnt to $clog2(DEBOUNCE_CYCLES) bits; the counter never wraps.
REQ-019 SHALL set edge[i] on the clock where stable[i] changes in the direction EDGE_MODE selects.
REQ-020 SHALL decode register map as: 0 = DATA (stable, RO); 1 = IRQ_MASK (RW, WIDTH bits); 2 = EDGE_CAP (read; writing 1 clears that bit); 3 = RAW (sync, RO).
REQ-021 SHALL zero-extend unused readdata bits to 32.
REQ-022 SHALL update readdata one clock after a read strobe with the selected register; readdata holds its value when read is low; fixed latency 1, no waitrequest.
REQ-023 SHALL let a new edge win over a write-1-to-clear in the same clock, so edge[i] remains 1.
REQ-024 SHALL ignore writes to addresses 0 and 3, and ignore writedata bits at or above WIDTH.
REQ-025 SHALL drive irq = |(EDGE_CAP & IRQ_MASK), registered, asserting one clock after the enabling edge or mask write.
REQ-026 SHALL make simultaneous read and write to the same address return the pre-write value.

Reset
REQ-027 SHALL asynchronously clear synchronizer flops, stable, cnt, EDGE_CAP, IRQ_MASK, readdata and irq to 0 on reset_n low.
REQ-028 SHALL release reset synchronously; a switch held at 1 through reset is accepted after 2 + DEBOUNCE_CYCLES clocks and then produces a rising edge.
REQ-029 SHALL abandon any partial debounce count when reset is asserted mid-count.

Structure
REQ-030 SHALL define register offsets (ADDR_DATA, ADDR_MASK, ADDR_EDGE, ADDR_RAW) and EDGE_MODE encodings in shared package sw_pio_pkg.
REQ-031 SHALL implement the per-bit synchronizer, counter and stable flop in one sub-module, sw_debounce_bit, instantiated WIDTH times with a generate loop.
REQ-032 SHALL keep the register file, edge capture and irq logic in the top level.

Verification
REQ-033 SHALL use bench parameters DEBOUNCE_CYCLES=4, WIDTH=4, EDGE_MODE=2.
REQ-034 SHALL cover steady input: sw_in[0] 0->1 held -> DATA reads 0x1 at clock 2+4 after the change, and EDGE_CAP reads 0x1.
REQ-035 SHALL cover glitch rejection: sw_in[1] high for 3 clocks then low -> DATA and EDGE_CAP stay 0x0.
REQ-036 SHALL cover interrupts: write IRQ_MASK=0x4, then debounce sw_in[2] 0->1 -> irq=1; write EDGE_CAP=0x4 -> irq=0 next clock.
REQ-037 SHALL cover the clear/edge collision: write EDGE_CAP=0x1 on the same clock bit 0 sets again -> EDGE_CAP stays 0x1.
REQ-038 SHALL cover reset mid-count: reset_n pulsed low at cnt=2 -> all registers read 0, and the switch is accepted 6 clocks after release.
